// File: rtl/widths_shift_seq_if.sv
// Request/result bus for the sequential shifter: a valid/ready request
// channel carrying operand, distance and operation, and a valid/ready
// result channel carrying the shifted word and the last bit shifted out.
interface widths_shift_seq_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    // Requester / result consumer side.
    modport master (
        output in_valid, data_in, shift_amt, mode, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    // Shifter side.
    modport slave (
        input  in_valid, data_in, shift_amt, mode, out_ready,
        output in_ready, out_valid, result, carry_out
    );
endinterface

// File: rtl/widths_shift_seq.sv
// Sequential shifter: performs one 1-bit step of SHL/SHR/SAR/ROL per cycle,
// so a shift by N reports its result N+1 cycles after the request is taken.
// The result is held until the consumer accepts it.
module widths_shift_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    widths_shift_seq_if.slave   bus
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {M_SHL = 2'b00, M_SHR = 2'b01, M_SAR = 2'b10, M_ROL = 2'b11} mode_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // One 1-bit step of the latched operation applied to the working word.
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        case (mode_t'(mode_q))
            M_SHL: begin
                step_data  = {data_q[WIDTH-2:0], 1'b0};
                step_carry = data_q[WIDTH-1];
            end
            M_SHR: begin
                step_data  = {1'b0, data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            M_SAR: begin
                step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            M_ROL: begin
                step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_carry = data_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Next-state and handshake outputs; inputs other than out_ready only
    // matter in IDLE.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        carry_d       = carry_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.data_in;
                    cnt_d   = bus.shift_amt;
                    mode_d  = bus.mode;
                    carry_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Count reaching zero costs one extra cycle with no data
                // change; that cycle is what makes latency amount+1.
                if (cnt_q != '0) begin
                    data_d  = step_data;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

    assign bus.result    = data_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_widths_shift_seq.sv
// Bench for widths_shift_seq (WIDTH=8): directed vectors, random operations
// against an arithmetic reference model, backpressure, back-to-back and
// mid-operation reset.
module tb_widths_shift_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    widths_shift_seq_if #(.WIDTH(W)) bus ();

    widths_shift_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Whole-shift reference: result and last bit shifted out computed directly.
    function automatic void model(input logic [7:0] d, input int n, input int m,
                                  output logic [7:0] r, output logic c);
        int dv, sv;
        dv = int'(d);
        r  = '0;
        c  = 1'b0;
        case (m)
            0: begin
                r = 8'((dv << n) & 255);
                c = (n != 0) ? 1'((dv >> (8 - n)) & 1) : 1'b0;
            end
            1: begin
                r = 8'(dv >> n);
                c = (n != 0) ? 1'((dv >> (n - 1)) & 1) : 1'b0;
            end
            2: begin
                sv = (dv >= 128) ? dv - 256 : dv;
                r  = 8'((sv >>> n) & 255);
                c  = (n != 0) ? 1'((dv >> (n - 1)) & 1) : 1'b0;
            end
            default: begin
                r = 8'(((dv << n) | (dv >> (8 - n))) & 255);
                c = (n != 0) ? 1'((dv >> (8 - n)) & 1) : 1'b0;
            end
        endcase
    endfunction

    // Issues one request, scrambles ignored inputs while busy, waits (bounded)
    // for out_valid, samples the result and lets the handshake happen.
    task automatic run_op(input logic [7:0] d, input int n, input int m,
                          output int lat, output logic [7:0] r, output logic c,
                          output bit busy_ok, output bit acc_ok);
        @(negedge clk);
        acc_ok        = (bus.in_ready === 1'b1);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.shift_amt = 3'(n);
        bus.mode      = 2'(m);
        @(posedge clk); #1;
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            bus.in_valid  = 1'($urandom);
            bus.data_in   = 8'($urandom);
            bus.shift_amt = 3'($urandom);
            bus.mode      = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
        r = bus.result;
        c = bus.carry_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        total++;
        if (bus.result !== 8'h00 || bus.carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: got result=%h carry=%b want 00 0", bus.result, bus.carry_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] dv [6] = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'h81, 8'h5A};
        int         nv [6] = '{3, 3, 3, 3, 7, 0};
        int         mv [6] = '{0, 1, 2, 3, 3, 2};
        logic [7:0] rv [6] = '{8'hA8, 8'h16, 8'hF6, 8'hAD, 8'hC0, 8'h5A};
        logic       cv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat; logic [7:0] r; logic c; bit bok, aok;
        for (int i = 0; i < 6; i++) begin
            run_op(dv[i], nv[i], mv[i], lat, r, c, bok, aok);
            total++;
            if (lat != nv[i] + 1 || r !== rv[i] || c !== cv[i] || !bok || !aok) begin
                bad++;
                $display("FAIL vector%0d: got lat=%0d res=%h carry=%b busy=%b acc=%b want lat=%0d res=%h carry=%b",
                         i, lat, r, c, bok, aok, nv[i] + 1, rv[i], cv[i]);
            end
        end
        // zero-distance in every mode
        for (int m = 0; m < 4; m++) begin
            run_op(8'h5A, 0, m, lat, r, c, bok, aok);
            total++;
            if (lat != 1 || r !== 8'h5A || c !== 1'b0) begin
                bad++;
                $display("FAIL zero_amt_m%0d: got lat=%0d res=%h carry=%b want 1 5a 0", m, lat, r, c);
            end
        end
    endtask

    task automatic test_random();
        int lat, n, m; logic [7:0] d, r, er; logic c, ec; bit bok, aok;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            n = int'($urandom_range(0, 7));
            m = int'($urandom_range(0, 3));
            model(d, n, m, er, ec);
            run_op(d, n, m, lat, r, c, bok, aok);
            total++;
            if (lat != n + 1 || r !== er || c !== ec || !bok || !aok) begin
                bad++;
                $display("FAIL random%0d d=%h n=%0d m=%0d: got lat=%0d res=%h carry=%b busy=%b acc=%b want lat=%0d res=%h carry=%b",
                         i, d, n, m, lat, r, c, bok, aok, n + 1, er, ec);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] er; logic ec; int lat; bit stable;
        model(8'hB5, 2, 0, er, ec);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = 8'hB5; bus.shift_amt = 3'd2; bus.mode = 2'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != 3 || bus.result !== er || bus.carry_out !== ec) begin
            bad++;
            $display("FAIL bp_result: got lat=%0d res=%h carry=%b want 3 %h %b", lat, bus.result, bus.carry_out, er, ec);
        end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid  = 1'(k & 1);
            bus.data_in   = 8'($urandom);
            bus.shift_amt = 3'($urandom);
            bus.mode      = 2'($urandom);
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== er || bus.carry_out !== ec) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold: got unstable DONE outputs (res=%h carry=%b ov=%b ir=%b) want %h %b 1 0",
                     bus.result, bus.carry_out, bus.out_valid, bus.in_ready, er, ec);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_single: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] r, er; logic c, ec; bit bok, aok;
        for (int i = 0; i < 3; i++) begin
            model(8'h3C + 8'(i), i + 1, 2 - i, er, ec);
            run_op(8'h3C + 8'(i), i + 1, 2 - i, lat, r, c, bok, aok);
            total++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || lat != i + 2 || r !== er || c !== ec || !aok) begin
                bad++;
                $display("FAIL b2b%0d: got ir=%b ov=%b lat=%0d res=%h carry=%b acc=%b want 1 0 %0d %h %b 1",
                         i, bus.in_ready, bus.out_valid, lat, r, c, aok, i + 2, er, ec);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] r, er; logic c, ec; bit bok, aok, quiet;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.data_in = 8'hE7; bus.shift_amt = 3'd4; bus.mode = 2'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.carry_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got ir=%b ov=%b res=%h carry=%b want 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.carry_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL mid_reset_quiet: got out_valid pulse or busy after reset want idle");
        end
        model(8'h96, 5, 3, er, ec);
        run_op(8'h96, 5, 3, lat, r, c, bok, aok);
        total++;
        if (lat != 6 || r !== er || c !== ec || !aok) begin
            bad++;
            $display("FAIL mid_reset_next: got lat=%0d res=%h carry=%b acc=%b want 6 %h %b 1", lat, r, c, aok, er, ec);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.shift_amt = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/widths_shift_seq.md
WIDTHS_SHIFT_SEQ -- requirements
Module: widths_shift_seq

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Derived constant: SHW = clog2(WIDTH), shift-amount width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 data_in  input  WIDTH  operand.
REQ-008 shift_amt  input  SHW  shift distance, 0..WIDTH-1.
REQ-009 mode  input  2  operation code: 00 SHL, 01 SHR logical, 10 SAR arithmetic, 11 ROL rotate-left.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  shifted operand.
REQ-013 carry_out  output  1  last bit moved out of the MSB/LSB end.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; exactly one active.
REQ-015 IDLE: in_ready=1, out_valid=0.
REQ-016 IDLE and in_valid=1: latch data_in, shift_amt, mode; clear carry_out; enter SHIFT.
REQ-017 SHIFT: in_ready=0, out_valid=0; cycle count = latched amount.
REQ-018 SHIFT, count>0: one 1-bit step of the latched mode; decrement count.
REQ-019 SHIFT, count=0: enter DONE on the next edge; no data change.
REQ-020 Latency: out_valid asserts exactly shift_amt+1 cycles after the accepting edge.
REQ-021 SHL step: zero into bit 0; carry_out := old MSB.
REQ-022 SHR step: zero into MSB; carry_out := old bit 0.
REQ-023 SAR step: old MSB replicated into MSB; carry_out := old bit 0.
REQ-024 ROL step: old MSB moves to bit 0; carry_out := old MSB.
REQ-025 shift_amt=0: result=data_in; carry_out=0.
REQ-026 DONE: out_valid=1, in_ready=0; result and carry_out held stable until the handshake.
REQ-027 DONE and out_ready=1: return to IDLE next edge; out_valid deasserts.
REQ-028 DONE to IDLE takes one cycle; a new request is accepted no earlier than the cycle after the result handshake.
REQ-029 Inputs other than out_ready are ignored in SHIFT and DONE.
REQ-030 in_valid in IDLE is accepted regardless of out_ready.
REQ-031 result reflects the working register in every state; it is only guaranteed valid while out_valid=1.

Reset
REQ-032 rst=1 forces IDLE immediately, without waiting for clk.
REQ-033 Reset values: in_ready=1, out_valid=0, result=0, carry_out=0, count=0.
REQ-034 rst during SHIFT or DONE discards the operation; no out_valid pulse is produced afterwards.
REQ-035 First accept is possible on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-036 SHL 0xB5 by 3 -> out_valid 4 cycles after accept; result 0xA8; carry_out 1.
REQ-037 SHR 0xB5 by 3 -> result 0x16, carry_out 1; SAR 0xB5 by 3 -> result 0xF6, carry_out 1.
REQ-038 ROL 0xB5 by 3 -> result 0xAD, carry_out 1; ROL 0x81 by 7 -> result 0xC0, carry_out 0.
REQ-039 shift_amt=0, data 0x5A, any mode -> out_valid 1 cycle after accept; result 0x5A; carry_out 0.
REQ-040 Backpressure: out_ready low for 5 cycles in DONE -> out_valid, result and carry_out stable; in_ready=0; in_valid pulses ignored; single handshake on release.
REQ-041 rst asserted in SHIFT with count=2 -> in_ready=1 and out_valid=0 before the next clk edge; next request completes normally.
